// File: rtl/johnson_counter.sv
// Johnson (twisted-ring) counter, modulus 2N. Supports up/down counting, synchronous load,
// phase decode and a wrap pulse. Define JOHNSON_SELF_CORRECT_EN to flag and recover illegal codes.
module johnson_counter #(
  parameter int N    = 4,
  parameter int INIT = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CE,
  input  logic                   DIR,
  input  logic                   LOAD,
  input  logic [N-1:0]           LOAD_VAL,
  output logic [N-1:0]           O,
  output logic [$clog2(2*N)-1:0] PHASE,
  output logic [2*N-1:0]         DECODE,
  output logic                   WRAP,
  output logic                   ILLEGAL
);

  localparam int PW = $clog2(2*N);

  // Phases 0..N fill ones upward from bit 0; phases N+1..2N-1 clear zeros upward from bit 0.
  function automatic logic [N-1:0] code_of(input int p);
    logic [N-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (p <= N) c[i] = (i < p);
      else        c[i] = (i >= p - N);
    end
    return c;
  endfunction

  localparam logic [N-1:0] INIT_CODE = code_of(INIT);
  localparam logic [N-1:0] LAST_CODE = code_of(2*N - 1);

  logic [N-1:0] o_q, o_d;
  logic         wrap_q, wrap_d;
  logic         lo_match, hi_match, legal, illegal;
  int           ones, ph;
  logic [N-1:0] fwd, rev;

  always_comb begin
    ones = 0;
    for (int i = 0; i < N; i++) ones = ones + 32'(o_q[i]);
    lo_match = (o_q == code_of(ones));
    hi_match = !o_q[0] && (ones > 0) && (o_q == code_of(2*N - ones));
    legal    = lo_match || hi_match;
    ph       = 0;
    if (lo_match)      ph = ones;
    else if (hi_match) ph = 2*N - ones;
    DECODE = '0;
    if (legal) DECODE[ph] = 1'b1;
`ifdef JOHNSON_SELF_CORRECT_EN
    illegal = !legal;
`else
    illegal = 1'b0;
`endif
  end

  always_comb begin
    fwd    = {o_q[N-2:0], ~o_q[N-1]};
    rev    = {~o_q[0], o_q[N-1:1]};
    o_d    = o_q;
    wrap_d = 1'b0;
    if (LOAD) begin
      o_d = LOAD_VAL;
    end else if (CE) begin
      // A step from an illegal code restarts at phase 0 and is not a wrap.
      if (illegal) begin
        o_d = '0;
      end else begin
        o_d    = DIR ? rev : fwd;
        wrap_d = DIR ? (o_q == '0) : (o_q == LAST_CODE);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_q    <= INIT_CODE;
      wrap_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      wrap_q <= wrap_d;
    end
  end

  assign O       = o_q;
  assign WRAP    = wrap_q;
  assign PHASE   = PW'(ph);
  assign ILLEGAL = illegal;

endmodule

// File: tb/tb_johnson_counter.sv
// Directed bench for johnson_counter: N=4/INIT=0, N=4/INIT=3 and N=5/INIT=0 instances.
module tb_johnson_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // N=4, INIT=0
  logic       rst4 = 1'b0, ce4 = 1'b0, dir4 = 1'b0, ld4 = 1'b0;
  logic [3:0] lv4 = '0, o4;
  logic [2:0] ph4;
  logic [7:0] dec4;
  logic       wrap4, ill4;

  // N=4, INIT=3
  logic       rst3 = 1'b0, ce3 = 1'b0, dir3 = 1'b0, ld3 = 1'b0;
  logic [3:0] lv3 = '0, o3;
  logic [2:0] ph3;
  logic [7:0] dec3;
  logic       wrap3, ill3;

  // N=5, INIT=0
  logic       rst5 = 1'b0, ce5 = 1'b0, dir5 = 1'b0, ld5 = 1'b0;
  logic [4:0] lv5 = '0, o5;
  logic [3:0] ph5;
  logic [9:0] dec5;
  logic       wrap5, ill5;

  johnson_counter #(.N(4), .INIT(0)) u_dut4 (
    .CLK(clk), .RESET(rst4), .CE(ce4), .DIR(dir4), .LOAD(ld4), .LOAD_VAL(lv4),
    .O(o4), .PHASE(ph4), .DECODE(dec4), .WRAP(wrap4), .ILLEGAL(ill4));

  johnson_counter #(.N(4), .INIT(3)) u_dut3 (
    .CLK(clk), .RESET(rst3), .CE(ce3), .DIR(dir3), .LOAD(ld3), .LOAD_VAL(lv3),
    .O(o3), .PHASE(ph3), .DECODE(dec3), .WRAP(wrap3), .ILLEGAL(ill3));

  johnson_counter #(.N(5), .INIT(0)) u_dut5 (
    .CLK(clk), .RESET(rst5), .CE(ce5), .DIR(dir5), .LOAD(ld5), .LOAD_VAL(lv5),
    .O(o5), .PHASE(ph5), .DECODE(dec5), .WRAP(wrap5), .ILLEGAL(ill5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the N=4/INIT=0 instance for one edge, then settle past the edge.
  task automatic step4(input logic r, input logic c, input logic d, input logic l,
                       input logic [3:0] v);
    @(negedge clk);
    rst4 = r; ce4 = c; dir4 = d; ld4 = l; lv4 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] eo, input logic [2:0] eph,
                      input logic ew);
    chk({tag, ".O"}, 32'(o4), 32'(eo));
    chk({tag, ".PHASE"}, 32'(ph4), 32'(eph));
    chk({tag, ".DECODE"}, 32'(dec4), 32'(8'(1) << eph));
    chk({tag, ".WRAP"}, 32'(wrap4), 32'(ew));
    chk({tag, ".ILLEGAL"}, 32'(ill4), 32'(0));
  endtask

  logic [3:0] up_o  [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                            4'b1100, 4'b1000, 4'b0000, 4'b0001};
  logic [2:0] up_ph [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic       up_w  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [4:0] tbl5  [10] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                             5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};

  initial begin
    int wraps;

    // Reset state
    step4(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk4("reset", 4'b0000, 3'd0, 1'b0);

    // Full forward period with a single wrap after 1000->0000
    for (int i = 0; i < 9; i++) begin
      step4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      chk4($sformatf("fwd%0d", i), up_o[i], up_ph[i], up_w[i]);
    end

    // Hold with CE low
    step4(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk4("hold", 4'b0001, 3'd1, 1'b0);

    // Load 0011 then reverse three steps through the wrap
    step4(1'b0, 1'b1, 1'b1, 1'b1, 4'b0011);
    chk4("ld0011", 4'b0011, 3'd2, 1'b0);
    step4(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk4("rev1", 4'b0001, 3'd1, 1'b0);
    step4(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk4("rev2", 4'b0000, 3'd0, 1'b0);
    step4(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk4("rev3", 4'b1000, 3'd7, 1'b1);
    step4(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk4("rev_hold", 4'b1000, 3'd7, 1'b0);

    // Direction change: no lost or repeated phase
    step4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk4("dirchg_fwd", 4'b0000, 3'd0, 1'b1);
    step4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk4("dirchg_fwd2", 4'b0001, 3'd1, 1'b0);
    step4(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk4("dirchg_rev", 4'b0000, 3'd0, 1'b0);

    // Count to 0111, then LOAD with CE high overrides the step
    step4(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk4("cnt0111", 4'b0111, 3'd3, 1'b0);
    step4(1'b0, 1'b1, 1'b0, 1'b1, 4'b1100);
    chk4("ld1100", 4'b1100, 3'd6, 1'b0);
    chk("ld1100.DECODE40", 32'(dec4), 32'h40);

    // LOAD from the last phase to phase 0 never produces WRAP
    step4(1'b0, 1'b1, 1'b0, 1'b1, 4'b1000);
    chk4("ld1000", 4'b1000, 3'd7, 1'b0);
    step4(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    chk4("ld0000_nowrap", 4'b0000, 3'd0, 1'b0);

    // RESET mid-count from the last phase abandons the step, no WRAP
    step4(1'b0, 1'b1, 1'b0, 1'b1, 4'b1000);
    step4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk4("rst_mid", 4'b0000, 3'd0, 1'b0);

    // Illegal code handling
    step4(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
    chk("ill_ld.O", 32'(o4), 32'h5);
`ifdef JOHNSON_SELF_CORRECT_EN
    chk("ill_ld.ILLEGAL", 32'(ill4), 32'd1);
    chk("ill_ld.DECODE", 32'(dec4), 32'd0);
    chk("ill_ld.PHASE", 32'(ph4), 32'd0);
    step4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk4("ill_fix", 4'b0000, 3'd0, 1'b0);
`else
    chk("ill_ld.ILLEGAL", 32'(ill4), 32'd0);
    step4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("ill_shift.O", 32'(o4), 32'hB);
    chk("ill_shift.ILLEGAL", 32'(ill4), 32'd0);
    chk("ill_shift.WRAP", 32'(wrap4), 32'd0);
`endif

    // INIT=3: RESET beats LOAD and CE
    @(negedge clk);
    rst3 = 1'b1; ld3 = 1'b1; ce3 = 1'b1; lv3 = 4'b1010;
    @(posedge clk);
    #1;
    chk("init3.O", 32'(o3), 32'h7);
    chk("init3.WRAP", 32'(wrap3), 32'd0);
    chk("init3.PHASE", 32'(ph3), 32'd3);
    chk("init3.DECODE", 32'(dec3), 32'h08);
    chk("init3.ILLEGAL", 32'(ill3), 32'd0);

    // N=5: CE every other cycle over 20 cycles, one full modulus-10 period
    @(negedge clk);
    rst5 = 1'b1;
    @(posedge clk);
    #1;
    chk("n5_reset.O", 32'(o5), 32'h0);
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst5 = 1'b0; ce5 = (i % 2 == 0);
      @(posedge clk);
      #1;
      chk($sformatf("n5_c%0d.O", i), 32'(o5), 32'(tbl5[i/2]));
      chk($sformatf("n5_c%0d.WRAP", i), 32'(wrap5), 32'(i == 18));
      if (wrap5) wraps++;
    end
    chk("n5_phase_end", 32'(ph5), 32'd0);
    chk("n5_wrap_count", 32'(wraps), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
